// File: rtl/adc_pkg.sv
// Shared ADC constants used by the ADC0808 capture interface and the averaging filter.
package adc_pkg;

   localparam int unsigned ADC_DATA_W         = 8;
   localparam int unsigned ADC_AVG_LOG2_DEPTH = 3;

endpackage

// File: rtl/adc_sample_ring.sv
// Ring buffer for the moving-average window: stores the last 2^LOG2_DEPTH samples,
// tracks the fill level and exposes the entry about to be overwritten.
module adc_sample_ring
   import adc_pkg::*;
#(
   parameter int unsigned DATA_W     = ADC_DATA_W,
   parameter int unsigned LOG2_DEPTH = ADC_AVG_LOG2_DEPTH
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              wr_en,
   input  logic [DATA_W-1:0] wr_data,
   output logic [DATA_W-1:0] oldest,
   output logic              primed
);

   localparam int DEPTH = 1 << LOG2_DEPTH;
   localparam logic [LOG2_DEPTH:0] FILL_FULL = {1'b1, {LOG2_DEPTH{1'b0}}};

   logic [DATA_W-1:0]     mem_q [DEPTH];
   logic [LOG2_DEPTH-1:0] wr_ptr_q;
   logic [LOG2_DEPTH:0]   fill_q;

   // Flush takes priority over a same-cycle write, so that sample is dropped.
   always_ff @(posedge clk) begin
      if (reset || flush) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         fill_q   <= '0;
      end else if (wr_en) begin
         mem_q[wr_ptr_q] <= wr_data;
         wr_ptr_q        <= wr_ptr_q + 1'b1;
         if (fill_q != FILL_FULL) begin
            fill_q <= fill_q + 1'b1;
         end
      end
   end

   assign oldest = mem_q[wr_ptr_q];
   assign primed = (fill_q == FILL_FULL);

endmodule

// File: rtl/adc_avg_filter.sv
// Moving-average filter behind the ADC0808 capture: running window sum, registered
// average with valid/ready output, threshold flag and sticky overrun.
module adc_avg_filter
   import adc_pkg::*;
#(
   parameter int unsigned DATA_W     = ADC_DATA_W,
   parameter int unsigned LOG2_DEPTH = ADC_AVG_LOG2_DEPTH
) (
   input  logic              CLK100MHZ,
   input  logic              reset,
   input  logic [DATA_W-1:0] sample_in,
   input  logic              sample_valid,
   input  logic              flush,
   input  logic [DATA_W-1:0] thresh,
   output logic [DATA_W-1:0] avg_out,
   output logic              avg_valid,
   input  logic              avg_ready,
   output logic              above,
   output logic              primed,
   output logic              overrun
);

   localparam int unsigned SUM_W = DATA_W + LOG2_DEPTH;

   logic [DATA_W-1:0] oldest;
   logic [SUM_W-1:0]  sum_q, sum_d;
   logic              upd_q, upd_d;
   logic [DATA_W-1:0] avg_q, avg_d;
   logic              valid_q, valid_d;
   logic              above_q, above_d;
   logic              overrun_q, overrun_d;
   logic [DATA_W-1:0] avg_now;
   logic              load;

   adc_sample_ring #(
      .DATA_W    (DATA_W),
      .LOG2_DEPTH(LOG2_DEPTH)
   ) u_ring (
      .clk    (CLK100MHZ),
      .reset  (reset),
      .flush  (flush),
      .wr_en  (sample_valid),
      .wr_data(sample_in),
      .oldest (oldest),
      .primed (primed)
   );

   assign avg_now = sum_q[SUM_W-1:LOG2_DEPTH];

   always_comb begin
      sum_d     = sum_q;
      upd_d     = 1'b0;
      avg_d     = avg_q;
      valid_d   = valid_q;
      above_d   = above_q;
      overrun_d = overrun_q;

      if (flush) begin
         sum_d = '0;
      end else if (sample_valid) begin
         // Oldest entry is read before the ring overwrites it on this edge.
         sum_d = sum_q + SUM_W'(sample_in) - SUM_W'(oldest);
         upd_d = 1'b1;
      end

      // A flush on the stage-2 edge cancels the in-flight result.
      load = upd_q && primed && !flush;
      if (load) begin
         avg_d   = avg_now;
         above_d = (avg_now >= thresh);
         valid_d = 1'b1;
         if (valid_q && !avg_ready) begin
            overrun_d = 1'b1;
         end
      end else if (valid_q && avg_ready) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge CLK100MHZ) begin
      if (reset) begin
         sum_q     <= '0;
         upd_q     <= 1'b0;
         avg_q     <= '0;
         valid_q   <= 1'b0;
         above_q   <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         sum_q     <= sum_d;
         upd_q     <= upd_d;
         avg_q     <= avg_d;
         valid_q   <= valid_d;
         above_q   <= above_d;
         overrun_q <= overrun_d;
      end
   end

   assign avg_out   = avg_q;
   assign avg_valid = valid_q;
   assign above     = above_q;
   assign overrun   = overrun_q;

endmodule
